// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU: one result bit per clock, LSB first.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] X,
  output logic             C_out,
  output logic             Zero,
  output logic             Err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] M_ADD  = 3'b000;
  localparam logic [2:0] M_AND  = 3'b001;
  localparam logic [2:0] M_OR   = 3'b010;
  localparam logic [2:0] M_XOR  = 3'b011;
  localparam logic [2:0] M_XNOR = 3'b100;
  localparam logic [2:0] M_SUB  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, x_q;
  logic [2:0]       mode_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, carry_d;
  logic             cout_q, err_q;
  logic             mode_legal, last_bit, b_eff, res_bit;

  assign mode_legal = (Mode < 3'd6);
  assign last_bit   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = mode_legal ? S_RUN : S_DONE;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == S_RUN);
    Done = (state_q == S_DONE);
  end

  // Operands shift right each RUN cycle, so bit 0 is always the bit in flight.
  always_comb begin
    b_eff   = b_q[0] ^ (mode_q == M_SUB);
    res_bit = 1'b0;
    carry_d = carry_q;
    case (mode_q)
      M_ADD, M_SUB: begin
        res_bit = a_q[0] ^ b_eff ^ carry_q;
        carry_d = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));
      end
      M_AND:   res_bit = a_q[0] & b_q[0];
      M_OR:    res_bit = a_q[0] | b_q[0];
      M_XOR:   res_bit = a_q[0] ^ b_q[0];
      M_XNOR:  res_bit = ~(a_q[0] ^ b_q[0]);
      default: res_bit = 1'b0;
    endcase
    acc_d = {res_bit, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      x_q     <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            mode_q  <= Mode;
            cnt_q   <= '0;
            carry_q <= (Mode == M_SUB);
            acc_q   <= '0;
            if (!mode_legal) begin
              x_q    <= '0;
              cout_q <= 1'b0;
              err_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          acc_q   <= acc_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            x_q    <= acc_d;
            cout_q <= carry_d;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign X     = x_q;
  assign C_out = cout_q;
  assign Zero  = (x_q == '0);
  assign Err   = err_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - table-driven bench for serial_alu at WIDTH=8.
module tb_serial_alu;

  logic       CLK = 1'b0;
  logic       RST, Start;
  logic [2:0] Mode;
  logic [7:0] A, B;
  logic       Busy, Done, C_out, Zero, Err;
  logic [7:0] X;

  int n_cmp = 0;
  int n_bad = 0;

  serial_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Mode(Mode), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .X(X), .C_out(C_out), .Zero(Zero), .Err(Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] x;
    logic       c;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},  32'(Busy),  32'd0);
    chk({tag, " done"},  32'(Done),  32'd0);
    chk({tag, " x"},     32'(X),     32'd0);
    chk({tag, " c_out"}, 32'(C_out), 32'd0);
    chk({tag, " zero"},  32'(Zero),  32'd1);
    chk({tag, " err"},   32'(Err),   32'd0);
  endtask

  // inject: 0 plain, 1 stray Start sampled at E3, 2 reset sampled at E4
  task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        input int inject, output int done_at, output int done_cnt,
                        output int busy_bad);
    int busy_until;
    logic legal;
    legal      = (m < 3'd6);
    busy_until = legal ? ((inject == 2) ? 4 : 8) : 0;
    done_at    = -1;
    done_cnt   = 0;
    busy_bad   = 0;
    @(negedge CLK);
    Start = 1'b1; Mode = m; A = a; B = b;
    @(posedge CLK);
    #1 Start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (Done) begin
        if (done_cnt == 0) done_at = k;
        done_cnt++;
      end
      if (Busy !== (k < busy_until)) busy_bad++;
      if (inject == 1 && k == 2) begin
        Start = 1'b1; Mode = 3'b110; A = 8'hFF; B = 8'hFF;
      end
      if (inject == 1 && k == 3) Start = 1'b0;
      if (inject == 2 && k == 3) RST = 1'b1;
      if (inject == 2 && k == 4) begin
        chk_reset_vals("mid-run reset");
        RST = 1'b0;
      end
    end
  endtask

  initial begin
    int da, dc, bb;
    vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    vecs[3]  = '{3'b100, 8'hF0, 8'hAA, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 8'hF0, 8'hAA, 8'hA0, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 8'hF0, 8'hAA, 8'hFA, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 8'hF0, 8'hAA, 8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{3'b110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{3'b101, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

    RST = 1'b1; Start = 1'b0; Mode = 3'b000; A = 8'h00; B = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, 0, da, dc, bb);
      chk($sformatf("v%0d done_count", i), 32'(dc), 32'd1);
      chk($sformatf("v%0d done_at", i), 32'(da), (vecs[i].mode < 3'd6) ? 32'd8 : 32'd0);
      chk($sformatf("v%0d busy", i), 32'(bb), 32'd0);
      chk($sformatf("v%0d x", i), 32'(X), 32'(vecs[i].x));
      chk($sformatf("v%0d c_out", i), 32'(C_out), 32'(vecs[i].c));
      chk($sformatf("v%0d zero", i), 32'(Zero), 32'(vecs[i].x == 8'h00));
      chk($sformatf("v%0d err", i), 32'(Err), 32'(vecs[i].err));
    end

    run_op(3'b000, 8'h11, 8'h22, 1, da, dc, bb);
    chk("stray start done_count", 32'(dc), 32'd1);
    chk("stray start done_at", 32'(da), 32'd8);
    chk("stray start busy", 32'(bb), 32'd0);
    chk("stray start x", 32'(X), 32'h33);
    chk("stray start err", 32'(Err), 32'd0);

    run_op(3'b000, 8'h11, 8'h22, 2, da, dc, bb);
    chk("reset abort done_count", 32'(dc), 32'd0);
    chk("reset abort busy", 32'(bb), 32'd0);

    run_op(3'b000, 8'h10, 8'h20, 0, da, dc, bb);
    chk("post-reset done_at", 32'(da), 32'd8);
    chk("post-reset done_count", 32'(dc), 32'd1);
    chk("post-reset x", 32'(X), 32'h30);
    chk("post-reset c_out", 32'(C_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port Start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The module SHALL have port Mode, input, 3 bits: opcode, sampled with Start.
REQ-006 The module SHALL have ports A and B, input, WIDTH bits each: operands, sampled with Start.
REQ-007 The module SHALL have port Busy, output, 1 bit: high while in RUN.
REQ-008 The module SHALL have port Done, output, 1 bit: high for exactly one cycle when the result becomes valid.
REQ-009 The module SHALL have port X, output, WIDTH bits: result.
REQ-010 The module SHALL have port C_out, output, 1 bit: final carry/no-borrow.
REQ-011 The module SHALL have port Zero, output, 1 bit: high when X is all zeros.
REQ-012 The module SHALL have port Err, output, 1 bit: high when the last accepted Mode was illegal.

Function
REQ-013 Modes SHALL be: 000 ADD (A+B), 001 AND, 010 OR, 011 XOR, 100 XNOR, 101 SUB (A+~B+1), 110/111 illegal.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, entering IDLE from reset.
REQ-015 In IDLE, when Start=1 at an edge, A, B and Mode SHALL be latched, the bit counter cleared, and the next state set to RUN (legal Mode) or DONE (illegal Mode).
REQ-016 On the accepting edge, the internal carry SHALL be initialised to 1 for SUB and to 0 for all other modes.
REQ-017 In RUN, each edge SHALL process exactly one bit, LSB first, using the latched operands.
REQ-018 For each RUN bit, the result bit and next carry SHALL be a full-adder sum/carry (ADD, SUB with B inverted) or the bitwise function (logic modes; carry unchanged at 0).
REQ-019 The bit-serial result SHALL be accumulated in an internal register.
REQ-020 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle, then return to IDLE.
REQ-022 Latency: for a legal Start accepted at edge E0, Busy SHALL be 1 from E0 to E0+WIDTH, and Done SHALL be 1 from E0+WIDTH to E0+WIDTH+1.
REQ-023 Latency: for an illegal Start accepted at edge E0, Done SHALL be 1 from E0 to E0+1, and Busy SHALL stay 0.
REQ-024 X, C_out, Zero and Err SHALL update only on the edge that enters DONE, and SHALL hold until the next DONE entry or reset.
REQ-025 C_out SHALL be the final carry for ADD/SUB (SUB: 1 = no borrow) and 0 for logic modes.
REQ-026 For an illegal Mode, X SHALL be 0, C_out 0, Zero 1 and Err 1.
REQ-027 Err SHALL be 0 after any legal operation.
REQ-028 Zero SHALL equal (X == 0) at all times.
REQ-029 Start SHALL be ignored in RUN and DONE, and A/B/Mode changes during RUN SHALL NOT affect the result.
REQ-030 Back-to-back: Start held high SHALL be accepted on the first IDLE edge after DONE, giving a period of WIDTH+2 cycles per legal operation.
REQ-031 Wrap-around: ADD/SUB results SHALL be modulo 2^WIDTH, with overflow reflected only in C_out.

Reset
REQ-032 When RST=1 at an edge, the FSM SHALL go to IDLE regardless of state or Start, and RST SHALL take priority over Start.
REQ-033 Reset values SHALL be: Busy=0, Done=0, X=0, C_out=0, Zero=1, Err=0; counter and carry cleared.
REQ-034 Reset during RUN or DONE SHALL abandon the operation with no Done pulse, and the first Start after RST deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-035 The bench SHALL cover: ADD A=0xFF B=0x01, Start at E0 -> Busy E0..E8, Done pulse E8..E9, X=0x00 C_out=1 Zero=1 Err=0.
REQ-036 The bench SHALL cover: SUB A=0x05 B=0x07 -> X=0xFE C_out=0 Zero=0; then SUB A=0x07 B=0x05 -> X=0x02 C_out=1.
REQ-037 The bench SHALL cover: XNOR A=0xF0 B=0xAA -> X=0xA5 C_out=0; AND 0xF0,0xAA -> 0xA0; OR -> 0xFA; XOR -> 0x5A.
REQ-038 The bench SHALL cover: Mode=110 Start at E0 -> Done E0..E1, Busy never 1, X=0x00 Err=1 Zero=1; next legal op -> Err=0.
REQ-039 The bench SHALL cover: Start pulsed at E3 during RUN with different A/B -> ignored, result of the first operation unchanged, only one Done.
REQ-040 The bench SHALL cover: RST at E4 mid-RUN -> IDLE next cycle, all outputs at reset values, no Done; a subsequent ADD 0x10+0x20 -> X=0x30 with nominal latency.
